// File: rtl/dfu_helper_ctl.sv
// dfu_helper_ctl: boot/DFU helper for iCE40 SoCs.
// Debounces the user button, classifies short and long presses, and issues a
// warm-boot request either from a button event or from a software command.
//
// Optional build macro: DFU_HELPER_WARMBOOT_PRIM_EN
//   defined   -> an SB_WARMBOOT primitive is instantiated and driven from wb_boot/wb_sel
//   undefined -> no primitive; wb_boot/wb_sel are driven identically for external use
//
// Press FSM states:
//   state    | meaning
//   IDLE     | button released, waiting for a debounced press
//   PRESS    | button held, press timer running
//   LONG     | long press just detected (one cycle)
//   WAIT_REL | long press already reported, waiting for release

module dfu_helper_ctl #(
    parameter int TIMER_WIDTH = 24,
    parameter int BTN_MODE    = 3,
    parameter int DFU_MODE    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       boot_now,
    input  logic [1:0] boot_sel,
    input  logic       btn_pad,
    output logic       btn_val,
    output logic       rst_req,
    output logic       wb_boot,
    output logic [1:0] wb_sel
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS    = 2'd1,
        LONG     = 2'd2,
        WAIT_REL = 2'd3
    } press_state_t;

    localparam logic [TIMER_WIDTH-1:0] TMR_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

    logic                   btn_meta;
    logic                   btn_sync;
    logic                   btn_pressed;
    logic [3:0]             dbnc_cnt;
    press_state_t           state;
    logic [TIMER_WIDTH-1:0] press_tmr;
    logic                   short_evt;
    logic                   long_evt;
    logic                   btn_rst_evt;
    logic                   btn_boot_req;
    logic [1:0]             btn_boot_img;
    logic                   boot_now_q;
    logic                   sw_req;
    logic                   boot_latched;
    logic [1:0]             boot_dly;

    // Two-flop synchronizer for the asynchronous button pad
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn_pad;
            btn_sync <= btn_meta;
        end
    end

    // Map the synced pad level to 1=pressed according to the pad polarity
    always_comb begin
        btn_pressed = 1'b0;
        if (BTN_MODE == 1)
            btn_pressed = btn_sync;
        else if (BTN_MODE >= 2)
            btn_pressed = ~btn_sync;
    end

    // Debounce: btn_val follows the pressed level only after 16 stable samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbnc_cnt <= 4'd0;
            btn_val  <= 1'b0;
        end else if (btn_pressed == btn_val) begin
            dbnc_cnt <= 4'd0;
        end else if (dbnc_cnt == 4'd15) begin
            dbnc_cnt <= 4'd0;
            btn_val  <= btn_pressed;
        end else begin
            dbnc_cnt <= dbnc_cnt + 4'd1;
        end
    end

    // Press classifier: one short or long event per press, registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            press_tmr <= '0;
            short_evt <= 1'b0;
            long_evt  <= 1'b0;
        end else begin
            short_evt <= 1'b0;
            long_evt  <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_val) begin
                        state     <= PRESS;
                        press_tmr <= '0;
                    end
                end
                PRESS: begin
                    if (!btn_val) begin
                        short_evt <= 1'b1;
                        state     <= IDLE;
                    end else if (press_tmr == '1) begin
                        long_evt <= 1'b1;
                        state    <= LONG;
                    end else begin
                        press_tmr <= press_tmr + TMR_ONE;
                    end
                end
                LONG: begin
                    state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!btn_val)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Event meaning depends on which image is running: the application resets on a
    // short press and enters DFU on a long one; the bootloader does the reverse.
    always_comb begin
        if (DFU_MODE == 0) begin
            btn_rst_evt  = short_evt;
            btn_boot_req = long_evt;
            btn_boot_img = 2'b01;
        end else begin
            btn_rst_evt  = long_evt;
            btn_boot_req = short_evt;
            btn_boot_img = 2'b10;
        end
    end

    assign sw_req = boot_now & ~boot_now_q;

    // Registered copy of boot_now for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            boot_now_q <= 1'b0;
        else
            boot_now_q <= boot_now;
    end

    // Reset request pulse; suppressed once a boot has been committed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rst_req <= 1'b0;
        else
            rst_req <= btn_rst_evt & ~boot_latched;
    end

    // Boot sequencer: latch image, hold it two cycles, then raise the sticky trigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_latched <= 1'b0;
            boot_dly     <= 2'd0;
            wb_sel       <= 2'b00;
            wb_boot      <= 1'b0;
        end else if (!boot_latched) begin
            if (sw_req) begin
                boot_latched <= 1'b1;
                wb_sel       <= boot_sel;
                boot_dly     <= 2'd1;
            end else if (btn_boot_req) begin
                boot_latched <= 1'b1;
                wb_sel       <= btn_boot_img;
                boot_dly     <= 2'd1;
            end
        end else if (!wb_boot) begin
            if (boot_dly == 2'd0)
                wb_boot <= 1'b1;
            else
                boot_dly <= boot_dly - 2'd1;
        end
    end

`ifdef DFU_HELPER_WARMBOOT_PRIM_EN
    SB_WARMBOOT u_warmboot (
        .BOOT (wb_boot),
        .S1   (wb_sel[1]),
        .S0   (wb_sel[0])
    );
`else
    // No primitive here: the warm-boot request is consumed outside this block.
`endif

endmodule

// File: tb/tb_dfu_helper_ctl.sv
// Scoreboard bench for dfu_helper_ctl: one instance per running image (DFU_MODE 0 and 1)
// shares the same stimulus; each gets its own expected-event queue.
module tb_dfu_helper_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       boot_now;
    logic [1:0] boot_sel;
    logic       btn_pad;

    logic       btn_val0, rst_req0, wb_boot0;
    logic [1:0] wb_sel0;
    logic       btn_val1, rst_req1, wb_boot1;
    logic [1:0] wb_sel1;

    always #5 clk = ~clk;

    dfu_helper_ctl #(.TIMER_WIDTH(8), .BTN_MODE(2), .DFU_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .boot_now(boot_now), .boot_sel(boot_sel),
        .btn_pad(btn_pad), .btn_val(btn_val0), .rst_req(rst_req0),
        .wb_boot(wb_boot0), .wb_sel(wb_sel0)
    );

    dfu_helper_ctl #(.TIMER_WIDTH(8), .BTN_MODE(2), .DFU_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .boot_now(boot_now), .boot_sel(boot_sel),
        .btn_pad(btn_pad), .btn_val(btn_val1), .rst_req(rst_req1),
        .wb_boot(wb_boot1), .wb_sel(wb_sel1)
    );

    typedef struct {
        bit         is_boot;
        logic [1:0] sel;
        int         deadline;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    bit  latched[2];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    bit         pb[2];
    logic [1:0] ps[2];
    int         age[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int k, input bit is_boot, input logic [1:0] sel, input int dl);
        ev_t e;
        e.is_boot  = is_boot;
        e.sel      = sel;
        e.deadline = dl;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_ev(input int k, output ev_t e, output bit ok);
        ok = 1'b0;
        e.is_boot = 1'b0; e.sel = 2'b00; e.deadline = 0;
        if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    endtask

    // Event codes: 0 = nothing expected, 1 = reset pulse, 2 = boot
    task automatic mon(input int k, input logic rr, input logic wb, input logic [1:0] ws);
        ev_t e;
        bit  ok;
        int  expk;
        if (!rst_n) begin
            pb[k]  = 1'b0;
            ps[k]  = 2'b00;
            age[k] = 100;
            return;
        end
        if (ws != ps[k]) age[k] = 1;
        else if (age[k] < 100) age[k]++;
        if (rr) begin
            pop_ev(k, e, ok);
            expk = ok ? (e.is_boot ? 2 : 1) : 0;
            chk(expk == 1, $sformatf("rst_req_event dut%0d", k), 1, expk);
        end
        if (wb && !pb[k]) begin
            pop_ev(k, e, ok);
            expk = ok ? (e.is_boot ? 2 : 1) : 0;
            chk(expk == 2, $sformatf("wb_boot_event dut%0d", k), 2, expk);
            if (ok && e.is_boot) begin
                chk(ws == e.sel, $sformatf("wb_sel dut%0d", k), int'(ws), int'(e.sel));
                chk(cyc <= e.deadline, $sformatf("boot_latency dut%0d", k), cyc, e.deadline);
                chk(age[k] >= 3, $sformatf("wb_sel_setup dut%0d", k), age[k], 3);
            end
        end
        if (pb[k])
            chk(wb == 1'b1, $sformatf("wb_boot_sticky dut%0d", k), int'(wb), 1);
        pb[k] = wb;
        ps[k] = ws;
    endtask

    always @(negedge clk) begin
        mon(0, rst_req0, wb_boot0, wb_sel0);
        mon(1, rst_req1, wb_boot1, wb_sel1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        chk(q0.size() == 0, "pending_events dut0", q0.size(), 0);
        chk(q1.size() == 0, "pending_events dut1", q1.size(), 0);
        q0.delete();
        q1.delete();
        rst_n    = 1'b0;
        boot_now = 1'b0;
        btn_pad  = 1'b1;
        tick(3);
        chk({btn_val0, rst_req0, wb_boot0, wb_sel0} == 5'd0, "reset_state dut0",
            int'({btn_val0, rst_req0, wb_boot0, wb_sel0}), 0);
        chk({btn_val1, rst_req1, wb_boot1, wb_sel1} == 5'd0, "reset_state dut1",
            int'({btn_val1, rst_req1, wb_boot1, wb_sel1}), 0);
        latched[0] = 1'b0;
        latched[1] = 1'b0;
        rst_n = 1'b1;
        tick(5);
    endtask

    // Reference: presses under 16 cycles are filtered, up to 240 are short,
    // 280 and longer are long. Image 0 (app): short=reset, long=boot image 1.
    // Image 1 (bootloader): short=boot image 2, long=reset. Nothing after a boot commit.
    task automatic press(input int n);
        int cls;
        bit seen;
        cls = (n < 16) ? 0 : ((n <= 240) ? 1 : 2);
        for (int k = 0; k < 2; k++) begin
            if (cls != 0 && !latched[k]) begin
                if ((k == 0 && cls == 1) || (k == 1 && cls == 2)) begin
                    push_ev(k, 1'b0, 2'b00, cyc + n + 400);
                end else begin
                    push_ev(k, 1'b1, (k == 0) ? 2'b01 : 2'b10, cyc + n + 400);
                    latched[k] = 1'b1;
                end
            end
        end
        seen = 1'b0;
        btn_pad = 1'b0;
        repeat (n) begin
            tick(1);
            seen |= btn_val0 | btn_val1;
        end
        btn_pad = 1'b1;
        repeat (60) begin
            tick(1);
            seen |= btn_val0 | btn_val1;
        end
        if (n < 16) chk(seen == 1'b0, "glitch_btn_val", int'(seen), 0);
        else        chk(seen == 1'b1, "press_btn_val", int'(seen), 1);
    endtask

    task automatic sw_boot(input logic [1:0] sel);
        boot_sel = sel;
        boot_now = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (!latched[k]) begin
                push_ev(k, 1'b1, sel, cyc + 3);
                latched[k] = 1'b1;
            end
        end
        tick(8);
        boot_now = 1'b0;
        tick(3);
    endtask

    initial begin
        bit seen;
        int r;
        rst_n    = 1'b0;
        boot_now = 1'b0;
        boot_sel = 2'b00;
        btn_pad  = 1'b1;
        tick(2);
        do_reset();

        // Quiet period after reset with the pad released
        seen = 1'b0;
        repeat (1000) begin
            tick(1);
            seen |= btn_val0 | btn_val1 | rst_req0 | rst_req1 | wb_boot0 | wb_boot1;
        end
        chk(seen == 1'b0, "idle_outputs", int'(seen), 0);

        // Debounce boundary, short presses, long press
        press(5);
        press(15);
        press(16);
        press(100);
        press(400);
        tick(50);
        chk(wb_boot0 == 1'b1 && wb_sel0 == 2'b01, "long_press_boot dut0",
            int'({wb_boot0, wb_sel0}), 5);
        chk(wb_boot1 == 1'b1 && wb_sel1 == 2'b10, "short_press_boot dut1",
            int'({wb_boot1, wb_sel1}), 6);
        do_reset();

        // Software boot, then a second edge that must be ignored
        sw_boot(2'b11);
        sw_boot(2'b10);
        chk(wb_sel0 == 2'b11, "sw_sel_held dut0", int'(wb_sel0), 3);
        chk(wb_sel1 == 2'b11, "sw_sel_held dut1", int'(wb_sel1), 3);
        do_reset();

        // Reset in the middle of a boot sequence: no boot may follow
        boot_sel = 2'b10;
        boot_now = 1'b1;
        tick(1);
        rst_n    = 1'b0;
        boot_now = 1'b0;
        tick(2);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick(1);
            seen |= wb_boot0 | wb_boot1;
        end
        chk(seen == 1'b0, "aborted_boot", int'(seen), 0);
        do_reset();

        // Random mix of glitches, presses, software boots and resets
        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(5, 0);
            case (r)
                0:       press($urandom_range(15, 1));
                1, 2:    press($urandom_range(240, 16));
                3:       press($urandom_range(450, 280));
                4:       sw_boot(2'($urandom_range(3, 0)));
                default: do_reset();
            endcase
        end
        tick(30);
        chk(q0.size() == 0, "final_pending dut0", q0.size(), 0);
        chk(q1.size() == 0, "final_pending dut1", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
